zint_sched: RTL and testbench

Interrupt-source scheduler for the TS-Conf Z80 interrupt controller. It holds the programmable interrupt configuration registers (HSINT, VSINT, LINSTEP, INTMASK) and watches the video raster, DMA engine and wait-port accesses. From these it produces the single-clock `int_start_*` strobes and the `intmask` byte consumed by `zint`. It sits between the port-write decoder, the video timing generator and `zint`.

---
 rtl/zint_pkg.sv | 14 +
 rtl/zint_linctr.sv | 19 +
 rtl/zint_sched.sv | 73 +++++++
 tb/tb_zint_sched.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/zint_pkg.sv
// zint_pkg: register indices, reset defaults and INTMASK bit positions shared by zint_sched and zint
package zint_pkg;
  localparam logic [7:0] A_HSINT     = 8'h22;
  localparam logic [7:0] A_VSINTL    = 8'h23;
  localparam logic [7:0] A_VSINTH    = 8'h24;
  localparam logic [7:0] A_LINSTEP   = 8'h25;
  localparam logic [7:0] A_INTMASK   = 8'h2A;
  localparam logic [7:0] HSINT_DEF   = 8'h01;
  localparam logic [7:0] INTMASK_DEF = 8'h01;
  localparam int IM_FRM = 0;
  localparam int IM_LIN = 1;
  localparam int IM_DMA = 2;
  localparam int IM_WTP = 3;
endpackage

// File: rtl/zint_linctr.sv
// zint_linctr: line-step down-counter; fires every linstep+1 lines and restarts at frame start
module zint_linctr (
  input  logic       clk,
  input  logic       res,
  input  logic       ce_i,
  input  logic       line_i,
  input  logic       frame_i,
  input  logic [7:0] linstep_i,
  output logic       fire_o
);
  logic [7:0] linctr_q, linctr_d;
  always_comb begin
    fire_o   = ce_i && line_i && (frame_i || linctr_q == 8'd0);
    linctr_d = fire_o ? linstep_i : (ce_i && line_i) ? linctr_q - 8'd1 : linctr_q;
  end
  always_ff @(posedge clk)
    if (res) linctr_q <= 8'd0;
    else     linctr_q <= linctr_d;
endmodule

// File: rtl/zint_sched.sv
// zint_sched: programmable INT registers and raster/DMA/wait-port event detection producing
// one-clock int_start_* strobes and the intmask byte for zint
module zint_sched #(
  parameter int         HW        = 9,
  parameter int         VW        = 9,
  parameter logic [7:0] A_HSINT   = zint_pkg::A_HSINT,
  parameter logic [7:0] A_VSINTL  = zint_pkg::A_VSINTL,
  parameter logic [7:0] A_VSINTH  = zint_pkg::A_VSINTH,
  parameter logic [7:0] A_LINSTEP = zint_pkg::A_LINSTEP,
  parameter logic [7:0] A_INTMASK = zint_pkg::A_INTMASK
) (
  input  logic          clk,
  input  logic          res,
  input  logic          ce,
  input  logic [HW-1:0] hcnt,
  input  logic [VW-1:0] vcnt,
  input  logic          reg_wr,
  input  logic [7:0]    reg_addr,
  input  logic [7:0]    reg_data,
  input  logic          dma_act,
  input  logic          wtp_acc,
  output logic          int_start_frm,
  output logic          int_start_lin,
  output logic          int_start_dma,
  output logic          int_start_wtp,
  output logic [7:0]    intmask
);
  import zint_pkg::*;
  logic [7:0] hsint_q, linstep_q;
  logic [8:0] vsint_q, vsint_pend_q;
  logic [3:0] intmask_q;
  logic       dma_act_q;
  logic       line_start, frame_start, frm_match, lin_fire;
  assign line_start  = hcnt == '0;
  assign frame_start = ce && line_start && vcnt == '0;
  assign frm_match   = ce && vcnt == VW'(vsint_q) && hcnt == HW'({hsint_q, 1'b0});
  assign intmask     = {4'b0, intmask_q};
  zint_linctr u_linctr (
    .clk       (clk),
    .res       (res),
    .ce_i      (ce),
    .line_i    (line_start),
    .frame_i   (frame_start),
    .linstep_i (linstep_q),
    .fire_o    (lin_fire)
  );
  // VSINT writes land in the pending copy so a mid-frame change never takes effect in the current frame
  always_ff @(posedge clk)
    if (res) begin
      hsint_q       <= HSINT_DEF;
      vsint_q       <= 9'h000;
      vsint_pend_q  <= 9'h000;
      linstep_q     <= 8'h00;
      intmask_q     <= INTMASK_DEF[3:0];
      dma_act_q     <= 1'b0;
      int_start_frm <= 1'b0;
      int_start_lin <= 1'b0;
      int_start_dma <= 1'b0;
      int_start_wtp <= 1'b0;
    end else begin
      if (reg_wr && reg_addr == A_HSINT)   hsint_q           <= reg_data;
      if (reg_wr && reg_addr == A_VSINTL)  vsint_pend_q[7:0] <= reg_data;
      if (reg_wr && reg_addr == A_VSINTH)  vsint_pend_q[8]   <= reg_data[0];
      if (reg_wr && reg_addr == A_LINSTEP) linstep_q         <= reg_data;
      if (reg_wr && reg_addr == A_INTMASK) intmask_q         <= reg_data[3:0];
      if (frame_start) vsint_q <= vsint_pend_q;
      dma_act_q     <= dma_act;
      int_start_frm <= frm_match;
      int_start_lin <= lin_fire;
      int_start_dma <= dma_act_q && !dma_act;
      int_start_wtp <= wtp_acc;
    end
endmodule

// File: tb/tb_zint_sched.sv
// tb_zint_sched: directed checks of zint_sched on a 16-clk x 320-line raster with ce every clock
module tb_zint_sched;
  localparam int LPL = 16;
  localparam int LPF = 320;
  logic       clk = 1'b0;
  logic       res, ce, reg_wr, dma_act, wtp_acc;
  logic [8:0] hcnt, vcnt;
  logic [7:0] reg_addr, reg_data, intmask;
  logic       int_start_frm, int_start_lin, int_start_dma, int_start_wtp;
  int n_vec = 0, n_bad = 0;
  int h = 0, v = 0, frm_cnt, lin_cnt, fpos_v, fpos_h, hold_cnt;
  bit both;
  bit [LPF-1:0] lin_lines;
  always #5 clk = ~clk;
  zint_sched dut (
    .clk(clk), .res(res), .ce(ce), .hcnt(hcnt), .vcnt(vcnt),
    .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_data(reg_data),
    .dma_act(dma_act), .wtp_acc(wtp_acc),
    .int_start_frm(int_start_frm), .int_start_lin(int_start_lin),
    .int_start_dma(int_start_dma), .int_start_wtp(int_start_wtp),
    .intmask(intmask)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clr_stats;
    frm_cnt = 0; lin_cnt = 0; fpos_v = -1; fpos_h = -1; both = 0; lin_lines = '0;
  endtask
  task automatic ras(input bit wr = 1'b0, input logic [7:0] a = 8'h00, input logic [7:0] d = 8'h00);
    ce = 1'b1; hcnt = h[8:0]; vcnt = v[8:0];
    reg_wr = wr; reg_addr = a; reg_data = d;
    tick;
    reg_wr = 1'b0;
    if (int_start_frm) begin frm_cnt++; fpos_v = v; fpos_h = h; end
    if (int_start_lin) begin lin_cnt++; lin_lines[v] = 1'b1; end
    if (int_start_frm && int_start_lin) both = 1'b1;
    h++;
    if (h == LPL) begin
      h = 0;
      v++;
      if (v == LPF) v = 0;
    end
  endtask
  task automatic run_until(input int tv);
    while (v != tv) ras();
  endtask
  task automatic run_frame_rest;
    do ras(); while (h != 0 || v != 0);
  endtask
  task automatic wr_idle(input logic [7:0] a, input logic [7:0] d);
    ce = 1'b0; reg_wr = 1'b1; reg_addr = a; reg_data = d;
    tick;
    reg_wr = 1'b0;
  endtask
  initial begin
    res = 1'b1; ce = 1'b0; hcnt = '0; vcnt = '0; reg_wr = 1'b0;
    reg_addr = '0; reg_data = '0; dma_act = 1'b0; wtp_acc = 1'b0;
    tick; tick;
    chk("rst_pulses", {int_start_frm, int_start_lin, int_start_dma, int_start_wtp}, 4'h0);
    chk("rst_intmask", intmask, 8'h01);
    res = 1'b0;
    clr_stats; run_frame_rest;
    chk("f1_frm_cnt", frm_cnt, 1);
    chk("f1_frm_v", fpos_v, 0);
    chk("f1_frm_h", fpos_h, 2);
    chk("f1_lin_cnt", lin_cnt, LPF);
    clr_stats;
    run_until(100);
    ras(1'b1, 8'h23, 8'h10);
    ras(1'b1, 8'h24, 8'h01);
    run_until(310);
    ras(1'b1, 8'h25, 8'h02);
    run_frame_rest;
    chk("f2_frm_cnt", frm_cnt, 1);
    chk("f2_frm_v", fpos_v, 0);
    clr_stats; run_frame_rest;
    chk("f3_frm_cnt", frm_cnt, 1);
    chk("f3_frm_v", fpos_v, 272);
    chk("f3_frm_h", fpos_h, 2);
    chk("f3_lin_cnt", lin_cnt, 107);
    chk("f3_lin_l3", lin_lines[3], 1);
    chk("f3_lin_l4", lin_lines[4], 0);
    chk("f3_lin_l318", lin_lines[318], 1);
    chk("f3_lin_l319", lin_lines[319], 0);
    clr_stats;
    run_until(100);
    ras();
    ras(1'b1, 8'h25, 8'h00);
    ras(1'b1, 8'h23, 8'hFF);
    run_frame_rest;
    chk("f4_frm_cnt", frm_cnt, 1);
    chk("f4_frm_v", fpos_v, 272);
    chk("f4_lin_cnt", lin_cnt, 252);
    chk("f4_lin_l99", lin_lines[99], 1);
    chk("f4_lin_l101", lin_lines[101], 0);
    chk("f4_lin_l102", lin_lines[102], 1);
    chk("f4_lin_l103", lin_lines[103], 1);
    clr_stats;
    run_until(50);
    ras(1'b1, 8'h22, 8'h00);
    ras(1'b1, 8'h23, 8'h05);
    ras(1'b1, 8'h24, 8'h00);
    run_frame_rest;
    chk("f5_line511_frm_cnt", frm_cnt, 0);
    clr_stats; run_frame_rest;
    chk("f6_frm_cnt", frm_cnt, 1);
    chk("f6_frm_v", fpos_v, 5);
    chk("f6_frm_h", fpos_h, 0);
    chk("f6_frm_lin_same_clk", both, 1);
    chk("f6_lin_cnt", lin_cnt, LPF);
    ce = 1'b0;
    dma_act = 1'b1; tick;
    chk("dma_rise", int_start_dma, 0);
    tick;
    dma_act = 1'b0; tick;
    chk("dma_fall", int_start_dma, 1);
    tick;
    chk("dma_single", int_start_dma, 0);
    wtp_acc = 1'b1; tick;
    wtp_acc = 1'b0;
    chk("wtp_pulse", int_start_wtp, 1);
    tick;
    chk("wtp_single", int_start_wtp, 0);
    ce = 1'b1; hcnt = 9'd0; vcnt = 9'd5; tick;
    chk("hold_first", {int_start_frm, int_start_lin}, 2'b11);
    ce = 1'b0; hold_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      hold_cnt += int'(int_start_frm) + int'(int_start_lin);
    end
    chk("hold_no_repeat", hold_cnt, 0);
    wr_idle(8'h2A, 8'hFA);
    chk("intmask_wr", intmask, 8'h0A);
    wr_idle(8'h26, 8'h00);
    chk("other_idx_ignored", intmask, 8'h0A);
    dma_act = 1'b1; tick;
    ce = 1'b1; hcnt = 9'd0; vcnt = 9'd5; dma_act = 1'b0; res = 1'b1;
    tick;
    chk("res_match_pulses", {int_start_frm, int_start_lin, int_start_dma}, 3'b000);
    res = 1'b0; ce = 1'b0;
    tick;
    chk("res_dma_lost", int_start_dma, 0);
    chk("res_intmask", intmask, 8'h01);
    h = 0; v = 0;
    clr_stats; run_frame_rest;
    chk("post_res_frm_cnt", frm_cnt, 1);
    chk("post_res_frm_v", fpos_v, 0);
    chk("post_res_frm_h", fpos_h, 2);
    chk("post_res_lin_cnt", lin_cnt, LPF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
